// File: rtl/vehicle_dynamics.sv
// Drive-state FSM, speed integrator and 0.1 km odometer driven by the speed/1 s tick strobes.
// Optional blinking overspeed warning is built when VEHICLE_OVERSPEED_EN is defined.
module vehicle_dynamics #(
   parameter int unsigned MAX_SPEED   = 200,
   parameter int unsigned ACCEL_STEP  = 2,
   parameter int unsigned BRAKE_STEP  = 5,
   parameter int unsigned COAST_STEP  = 1,
   parameter int unsigned SPEED_LIMIT = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_speed,
   input  logic        tick_1sec,
   input  logic        engine_on,
   input  logic        accel,
   input  logic        brake,
   output logic [7:0]  speed,
   output logic [1:0]  state,
   output logic        moving,
   output logic [16:0] odo,
   output logic        overspeed
);

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_ACCEL = 2'd1,
      ST_COAST = 2'd2,
      ST_BRAKE = 2'd3
   } drive_state_e;

   localparam logic [9:0]  DIST_UNIT = 10'd360;
   localparam logic [16:0] ODO_MAX   = 17'd99999;

   if (MAX_SPEED > 255 || SPEED_LIMIT > 255) begin : g_param_check
      $error("vehicle_dynamics: MAX_SPEED and SPEED_LIMIT must fit in 8 bits");
   end

   drive_state_e state_q, state_d;
   logic [7:0]   speed_q, speed_d;
   logic         moving_q;
   logic [8:0]   dacc_q;
   logic [16:0]  odo_q;

   logic [8:0]   spd_add, spd_brk, spd_cst;
   logic [9:0]   dacc_sum;

   always_comb begin
      state_d = ST_COAST;
      if (brake)                  state_d = (speed_q != 8'd0) ? ST_BRAKE : ST_STOP;
      else if (accel && engine_on) state_d = ST_ACCEL;
      else if (speed_q == 8'd0)    state_d = ST_STOP;
   end

   // Nine-bit arithmetic: bit 8 of a difference flags an underflow to clamp at 0.
   always_comb begin
      spd_add = {1'b0, speed_q} + 9'(ACCEL_STEP);
      spd_brk = {1'b0, speed_q} - 9'(BRAKE_STEP);
      spd_cst = {1'b0, speed_q} - 9'(COAST_STEP);
      speed_d = speed_q;
      if (tick_speed) begin
         case (state_q)
            ST_ACCEL: speed_d = (spd_add > 9'(MAX_SPEED)) ? 8'(MAX_SPEED) : spd_add[7:0];
            ST_BRAKE: speed_d = spd_brk[8] ? 8'd0 : spd_brk[7:0];
            ST_COAST: speed_d = spd_cst[8] ? 8'd0 : spd_cst[7:0];
            default:  speed_d = 8'd0;
         endcase
      end
   end

   assign dacc_sum = {1'b0, dacc_q} + {2'b00, speed_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_STOP;
         speed_q  <= 8'd0;
         moving_q <= 1'b0;
         dacc_q   <= 9'd0;
         odo_q    <= 17'd0;
      end else begin
         state_q  <= state_d;
         speed_q  <= speed_d;
         moving_q <= (speed_q != 8'd0);
         // Pre-update speed is integrated, so a coincident speed tick does not leak in.
         if (tick_1sec) begin
            if (dacc_sum >= DIST_UNIT) begin
               dacc_q <= 9'(dacc_sum - DIST_UNIT);
               odo_q  <= (odo_q == ODO_MAX) ? 17'd0 : odo_q + 17'd1;
            end else begin
               dacc_q <= dacc_sum[8:0];
            end
         end
      end
   end

`ifdef VEHICLE_OVERSPEED_EN
   logic over_q;

   always_ff @(posedge clk) begin
      if (rst)                              over_q <= 1'b0;
      else if (speed_q > 8'(SPEED_LIMIT)) begin
         if (tick_1sec)                      over_q <= ~over_q;
      end else                              over_q <= 1'b0;
   end

   assign overspeed = over_q;
`else
   assign overspeed = 1'b0;
`endif

   assign speed  = speed_q;
   assign state  = state_q;
   assign moving = moving_q;
   assign odo    = odo_q;

endmodule

// File: doc/vehicle_dynamics.md
# vehicle_dynamics

Vehicle motion core directly downstream of the clock-tick generator. It consumes the single-cycle `tick_speed` (every 2,500,000 clk, 0.05 s at 50 MHz) and `tick_1sec` (every 50,000,000 clk) strobes together with pedal inputs. It maintains a drive-state FSM, the current speed in km/h and a 0.1 km odometer. Its outputs feed the 7-segment display, LED and sound stages.

## Interface
- `MAX_SPEED`, default 200: speed ceiling, km/h; must be ≤ 255.
- `ACCEL_STEP`, default 2: speed increase per `tick_speed` in ACCEL.
- `BRAKE_STEP`, default 5: speed decrease per `tick_speed` in BRAKE.
- `COAST_STEP`, default 1: speed decrease per `tick_speed` in COAST.
- `SPEED_LIMIT`, default 100: overspeed threshold, km/h; used only with the macro.
- `clk` in 1: 50 MHz system clock.
- `rst` in 1: reset, synchronous, active-high.
- `tick_speed` in 1: one-cycle speed-update strobe.
- `tick_1sec` in 1: one-cycle 1 s strobe.
- `engine_on` in 1: 0 makes `accel` ignored.
- `accel` in 1: accelerator pedal, level.
- `brake` in 1: brake pedal, level; has priority over `accel`.
- `speed` out 8: current speed, km/h.
- `state` out 2: 0 STOP, 1 ACCEL, 2 COAST, 3 BRAKE.
- `moving` out 1: registered; 1 when `speed` ≠ 0.
- `odo` out 17: odometer in 0.1 km units, range 0–99999.
- `overspeed` out 1: blinking overspeed warning.

## Operation
- Reset: one clock with `rst`=1 sets `speed`=0, `state`=STOP, `moving`=0, `odo`=0, internal distance accumulator `dacc`=0 and `overspeed`=0. Reset overrides all ticks in the same cycle.
- State register updates every clk, independent of ticks. Priority order:
  - `brake` & `speed`≠0 → BRAKE
  - `brake` & `speed`=0 → STOP
  - `accel` & `engine_on` → ACCEL
  - `speed`=0 → STOP
  - otherwise → COAST
- Speed updates only on a cycle with `tick_speed`=1, using the registered `state` of that cycle:
  - ACCEL: min(`speed`+ACCEL_STEP, MAX_SPEED).
  - BRAKE: max(`speed`−BRAKE_STEP, 0).
  - COAST: max(`speed`−COAST_STEP, 0).
  - STOP: hold 0.
- Saturating subtraction is done in 9 bits with no wrap below 0. Addition is clamped; the result never exceeds MAX_SPEED.
- Distance: on `tick_1sec`, `dacc` (9 bits) += `speed`. One km/h for 1 s equals 1/3600 km, so 360 units equal 0.1 km.
  - If the sum is ≥ 360: `dacc` = sum − 360 and `odo` increments.
  - Since `speed` ≤ 255 < 360, at most one increment occurs per second.
- `odo` wraps 99999 → 0. `dacc` keeps its remainder through the wrap.
- Simultaneous `tick_speed` and `tick_1sec`: the distance accumulation uses the pre-update `speed`, i.e. the register value in that cycle.
- A pedal change between ticks changes `state` only; `speed` waits for the next `tick_speed`.

## Timing
- Input → `state`: 1 clk latency.
- `tick_speed` cycle → new `speed` visible next clk. `moving` follows `speed` by 1 further clk.
- `tick_1sec` cycle → `dacc`/`odo` visible next clk.
- Worst case from pedal press to first speed change is 1 clk + up to 2,500,000 clk.
- Ticks are assumed single-cycle. A tick held high for N cycles applies N updates; this is not filtered.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro `VEHICLE_OVERSPEED_EN`.
- Defined:
  - On each `tick_1sec` with `speed` > SPEED_LIMIT, `overspeed` toggles, giving a 0.5 Hz blink.
  - When `speed` ≤ SPEED_LIMIT, `overspeed` is forced to 0 on the next clk.
- Undefined: `overspeed` is constant 0, the port remains and no comparison logic is synthesized.

## Test plan
- Reset, then `accel`=1, `engine_on`=1, 10 `tick_speed` pulses → `state`=ACCEL after 1 clk; `speed`=20; `moving`=1.
- Hold `accel` for 150 `tick_speed` → `speed` saturates at 200 and stays 200.
- From `speed`=12, `brake`=1 and 3 ticks → `speed` 7, 2, 0; `state` BRAKE → STOP; `accel`=1 with `brake`=1 keeps STOP.
- `speed` fixed at 180: 2 `tick_1sec` → `odo`=1, `dacc`=0. With `odo` preloaded to 99999 and one more crossing → `odo`=0.
- `tick_speed` and `tick_1sec` in the same cycle at `speed`=100 in ACCEL → `dacc` += 100; `speed`=102; `engine_on`=0 with `accel`=1 → COAST, `speed` decreases 1 per tick.
- With `VEHICLE_OVERSPEED_EN`: `speed`=120, 3 `tick_1sec` → `overspeed` 1, 0, 1; brake to 100 → `overspeed`=0. Without the macro → `overspeed` stays 0.
